// File: rtl/merge_rr_pkg.sv
// Shared interconnect definitions for the round-robin merge: bus record
// widths, slice-width helpers and the two FSM state codes.
package merge_rr_pkg;

   // Request record, MSB first: {valid, addr, wdata, wstrb}.
   function automatic int req_w(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   // Response record, MSB first: {rdata, ready}; ready is bit 0.
   function automatic int resp_w(input int data_w);
      return data_w + 1;
   endfunction

   // Master index width; a single master still gets a 1-bit index.
   function automatic int sel_w(input int n_masters);
      return (n_masters > 1) ? $clog2(n_masters) : 1;
   endfunction

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/merge_rr_rr_arbiter.sv
// Combinational round-robin pick: first valid master strictly above 'last',
// otherwise the lowest valid master at or below it (the wrap-around).
module rr_arbiter
   import merge_rr_pkg::*;
#(
   parameter int N_MASTERS = 2
) (
   input  logic [N_MASTERS-1:0]        valid,
   input  logic [sel_w(N_MASTERS)-1:0] last,
   output logic [sel_w(N_MASTERS)-1:0] winner
);

   localparam int SEL_W = sel_w(N_MASTERS);

   logic [SEL_W-1:0] hi_win;
   logic [SEL_W-1:0] lo_win;
   logic             hi_found;

   // Scan downward so the lowest candidate in each half overwrites the others.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves a value held and no latch is inferred.
      hi_win   = '0;
      lo_win   = '0;
      hi_found = 1'b0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (valid[i]) begin
            if (SEL_W'(i) > last) begin
               hi_win   = SEL_W'(i);
               hi_found = 1'b1;
            end else begin
               lo_win = SEL_W'(i);
            end
         end
      end
      winner = hi_found ? hi_win : lo_win;
   end

endmodule

// File: rtl/merge_rr.sv
// N-to-1 native-bus merge: round-robin grant in IDLE, then the granted
// master is connected straight through to the slave until it answers ready.
module merge_rr
   import merge_rr_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int N_MASTERS = 2
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [N_MASTERS*req_w(ADDR_W, DATA_W)-1:0]   m_req,
   output logic [N_MASTERS*resp_w(DATA_W)-1:0]          m_resp,
   output logic [req_w(ADDR_W, DATA_W)-1:0]             s_req,
   input  logic [resp_w(DATA_W)-1:0]                    s_resp
);

   localparam int               REQ_W    = req_w(ADDR_W, DATA_W);
   localparam int               RESP_W   = resp_w(DATA_W);
   localparam int               SEL_W    = sel_w(N_MASTERS);
   localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_MASTERS - 1);

   logic [0:0]           state;
   logic [SEL_W-1:0]     sel;
   logic [SEL_W-1:0]     last;
   logic [SEL_W-1:0]     winner;
   logic [N_MASTERS-1:0] valid;
   logic                 any_valid;

   // Gather the valid bit (MSB of each request slice) from every master.
   always_comb begin
      valid = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         valid[i] = m_req[i*REQ_W + REQ_W - 1];
      end
   end

   assign any_valid = |valid;

   rr_arbiter #(
      .N_MASTERS (N_MASTERS)
   ) u_arb (
      .valid  (valid),
      .last   (last),
      .winner (winner)
   );

   // Grant on the edge after a valid is seen; release on the slave's ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         sel   <= '0;
         last  <= LAST_RST;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
         case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  sel   <= winner;
                  state <= ST_BUSY;
               end
            end
            default: begin
               if (s_resp[0]) begin
                  last  <= sel;
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Route the granted master to the slave; s_req never depends on s_resp.
   always_comb begin
      s_req  = '0;
      m_resp = '0;
      if (state == ST_BUSY) begin
         for (int i = 0; i < N_MASTERS; i++) begin
            if (sel == SEL_W'(i)) begin
               s_req                      = m_req[i*REQ_W +: REQ_W];
               m_resp[i*RESP_W +: RESP_W] = s_resp;
            end
         end
      end
   end

endmodule

// File: tb/tb_merge_rr.sv
// Bench for merge_rr: three instances (2, 4 and 1 masters) run side by side
// against a transaction-level round-robin model held in plain arrays.
module tb_merge_rr;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int REQ_W  = 1 + AW + DW + DW / 8;
   localparam int RESP_W = DW + 1;
   localparam int NI     = 3;
   localparam int NM [NI] = '{2, 4, 1};

   localparam int MODE_ONESHOT = 0;
   localparam int MODE_CONT    = 1;
   localparam int MODE_RAND    = 2;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW/8-1:0] wstrb;
   } req_t;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          ready;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   req_t  mreq  [NI][4];
   resp_t sresp [NI];

   logic [2*REQ_W-1:0]  m_req_a;
   logic [2*RESP_W-1:0] m_resp_a;
   logic [REQ_W-1:0]    s_req_a;
   logic [RESP_W-1:0]   s_resp_a;
   logic [4*REQ_W-1:0]  m_req_b;
   logic [4*RESP_W-1:0] m_resp_b;
   logic [REQ_W-1:0]    s_req_b;
   logic [RESP_W-1:0]   s_resp_b;
   logic [REQ_W-1:0]    m_req_c;
   logic [RESP_W-1:0]   m_resp_c;
   logic [REQ_W-1:0]    s_req_c;
   logic [RESP_W-1:0]   s_resp_c;

   assign m_req_a  = {mreq[0][1], mreq[0][0]};
   assign m_req_b  = {mreq[1][3], mreq[1][2], mreq[1][1], mreq[1][0]};
   assign m_req_c  = mreq[2][0];
   assign s_resp_a = sresp[0];
   assign s_resp_b = sresp[1];
   assign s_resp_c = sresp[2];

   merge_rr #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(2)) u_a (
      .clk(clk), .rst(rst), .m_req(m_req_a), .m_resp(m_resp_a),
      .s_req(s_req_a), .s_resp(s_resp_a));
   merge_rr #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(4)) u_b (
      .clk(clk), .rst(rst), .m_req(m_req_b), .m_resp(m_resp_b),
      .s_req(s_req_b), .s_resp(s_resp_b));
   merge_rr #(.DATA_W(DW), .ADDR_W(AW), .N_MASTERS(1)) u_c (
      .clk(clk), .rst(rst), .m_req(m_req_c), .m_resp(m_resp_c),
      .s_req(s_req_c), .s_resp(s_resp_c));

   always #5 clk = ~clk;

   // Reference model state (transaction level).
   int  busy [NI];
   int  gnt  [NI];
   int  last [NI];
   int  wait_cnt [NI];
   int  lat  [NI];
   bit  done [NI][4];
   bit  pend [NI][4];
   bit  en   [NI][4];
   bit  rand_lat;
   bit  fixed_rdata_en;
   logic [DW-1:0] fixed_rdata;
   int  mode;
   bit  chk_x;

   int  vectors = 0;
   int  miscompares = 0;
   int  cyc = 0;
   int  focus = -1;
   int  obs_q [$];
   int  pcyc_q [$];
   resp_t cap_r0, cap_r1;

   function automatic req_t get_sreq(input int inst);
      case (inst)
         0:       return s_req_a;
         1:       return s_req_b;
         default: return s_req_c;
      endcase
   endfunction

   function automatic resp_t get_resp(input int inst, input int i);
      case (inst)
         0:       return m_resp_a[i*RESP_W +: RESP_W];
         1:       return m_resp_b[i*RESP_W +: RESP_W];
         default: return m_resp_c;
      endcase
   endfunction

   // Round-robin rule: first valid master from (prev+1) mod n, wrapping.
   function automatic int rr_pick(input int prev, input int n, input int inst);
      for (int k = 1; k <= n; k++) begin
         int idx;
         idx = (prev + k) % n;
         if (mreq[inst][idx].valid) return idx;
      end
      return -1;
   endfunction

   task automatic new_req(input int inst, input int m);
      mreq[inst][m].valid = 1'b1;
      mreq[inst][m].addr  = $urandom;
      mreq[inst][m].wdata = $urandom;
      mreq[inst][m].wstrb = 4'($urandom_range(0, 15));
   endtask

   task automatic drive_slaves();
      for (int inst = 0; inst < NI; inst++) begin
         sresp[inst].ready = (busy[inst] != 0) && (wait_cnt[inst] == lat[inst]);
         sresp[inst].rdata = fixed_rdata_en ? fixed_rdata : DW'($urandom);
      end
   endtask

   task automatic check_outputs();
      for (int inst = 0; inst < NI; inst++) begin
         req_t exp_s, act_s;
         exp_s = (busy[inst] != 0) ? mreq[inst][gnt[inst]] : '0;
         act_s = get_sreq(inst);
         vectors++;
         if (act_s !== exp_s) begin
            miscompares++;
            $display("FAIL s_req inst%0d cyc%0d: got %h want %h", inst, cyc, act_s, exp_s);
         end
         for (int i = 0; i < NM[inst]; i++) begin
            resp_t exp_r, act_r;
            exp_r = (busy[inst] != 0 && gnt[inst] == i) ? sresp[inst] : '0;
            act_r = get_resp(inst, i);
            vectors++;
            if (act_r !== exp_r) begin
               miscompares++;
               $display("FAIL m_resp inst%0d slice%0d cyc%0d: got %h want %h",
                        inst, i, cyc, act_r, exp_r);
            end
         end
      end
      if (focus >= 0) begin
         for (int i = 0; i < NM[focus]; i++) begin
            if (get_resp(focus, i).ready === 1'b1) begin
               obs_q.push_back(i);
               pcyc_q.push_back(cyc);
               if (focus == 0) begin
                  cap_r0 = get_resp(0, 0);
                  cap_r1 = get_resp(0, 1);
               end
            end
         end
      end
      if (chk_x) begin
         vectors++;
         if ($isunknown(u_c.sel)) begin
            miscompares++;
            $display("FAIL n1_sel_x cyc%0d: got %b want known 0", cyc, u_c.sel);
         end
      end
   endtask

   // One clock: check outputs at negedge, advance model at posedge, restimulate.
   task automatic cycle();
      drive_slaves();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      for (int inst = 0; inst < NI; inst++)
         for (int m = 0; m < 4; m++) done[inst][m] = 1'b0;
      for (int inst = 0; inst < NI; inst++) begin
         if (busy[inst] == 0) begin
            int w;
            w = rr_pick(last[inst], NM[inst], inst);
            if (w >= 0) begin
               busy[inst]     = 1;
               gnt[inst]      = w;
               wait_cnt[inst] = 0;
               if (rand_lat) lat[inst] = $urandom_range(0, 3);
            end
         end else if (sresp[inst].ready) begin
            busy[inst] = 0;
            last[inst] = gnt[inst];
            done[inst][gnt[inst]] = 1'b1;
         end else begin
            wait_cnt[inst]++;
         end
      end
      #1;
      for (int inst = 0; inst < NI; inst++) begin
         for (int m = 0; m < NM[inst]; m++) begin
            if (en[inst][m]) begin
               if (done[inst][m]) begin
                  pend[inst][m] = 1'b0;
                  if (mode == MODE_CONT) new_req(inst, m);
                  else mreq[inst][m] = '0;
               end else if (mode == MODE_RAND) begin
                  if (!pend[inst][m]) begin
                     if ($urandom_range(0, 3) == 0) begin
                        new_req(inst, m);
                        pend[inst][m] = 1'b1;
                     end
                  end else begin
                     mreq[inst][m].valid = ($urandom_range(0, 7) != 0);
                  end
               end
            end
         end
      end
      cyc++;
   endtask

   task automatic run_until(input int npulse, input int budget, input string tag);
      int n;
      n = 0;
      while (obs_q.size() < npulse && n < budget) begin
         cycle();
         n++;
      end
      vectors++;
      if (obs_q.size() < npulse) begin
         miscompares++;
         $display("FAIL %s timeout: got %0d ready pulses want %0d", tag, obs_q.size(), npulse);
      end
   endtask

   task automatic check_order(input string tag, input int exp_q [$]);
      for (int k = 0; k < exp_q.size(); k++) begin
         int got;
         got = (k < obs_q.size()) ? obs_q[k] : -1;
         vectors++;
         if (got != exp_q[k]) begin
            miscompares++;
            $display("FAIL %s grant%0d: got master %0d want %0d", tag, k, got, exp_q[k]);
         end
      end
   endtask

   task automatic check_spacing(input string tag, input int gap);
      for (int k = 1; k < pcyc_q.size(); k++) begin
         vectors++;
         if (pcyc_q[k] - pcyc_q[k-1] != gap) begin
            miscompares++;
            $display("FAIL %s spacing%0d: got %0d cycles want %0d",
                     tag, k, pcyc_q[k] - pcyc_q[k-1], gap);
         end
      end
   endtask

   // Assert reset, check outputs are already zero, then clear bench state.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      for (int inst = 0; inst < NI; inst++) begin
         vectors++;
         if (get_sreq(inst) !== '0) begin
            miscompares++;
            $display("FAIL reset_s_req inst%0d: got %h want 0", inst, get_sreq(inst));
         end
         for (int i = 0; i < NM[inst]; i++) begin
            vectors++;
            if (get_resp(inst, i) !== '0) begin
               miscompares++;
               $display("FAIL reset_m_resp inst%0d slice%0d: got %h want 0",
                        inst, i, get_resp(inst, i));
            end
         end
      end
      for (int inst = 0; inst < NI; inst++) begin
         busy[inst] = 0; gnt[inst] = 0; last[inst] = NM[inst] - 1;
         wait_cnt[inst] = 0; lat[inst] = 0; sresp[inst] = '0;
         for (int m = 0; m < 4; m++) begin
            mreq[inst][m] = '0; en[inst][m] = 1'b0; pend[inst][m] = 1'b0;
            done[inst][m] = 1'b0;
         end
      end
      rand_lat = 1'b0; fixed_rdata_en = 1'b0; fixed_rdata = '0;
      mode = MODE_ONESHOT; chk_x = 1'b0; focus = -1;
      obs_q.delete(); pcyc_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (2) cycle();
   endtask

   task automatic test_single_write();
      int c0;
      do_reset();
      focus = 0;
      en[0][0] = 1'b1;
      mreq[0][0] = '{valid: 1'b1, addr: 32'h10, wdata: 32'hA5A5A5A5, wstrb: 4'hF};
      lat[0] = 3;
      c0 = cyc;
      run_until(1, 20, "single_write");
      repeat (3) cycle();
      vectors++;
      if (obs_q.size() != 1) begin
         miscompares++;
         $display("FAIL single_write pulses: got %0d want 1", obs_q.size());
      end
      check_order("single_write", '{0});
      vectors++;
      if (pcyc_q.size() > 0 && pcyc_q[0] - c0 != 4) begin
         miscompares++;
         $display("FAIL single_write latency: got %0d want 4", pcyc_q[0] - c0);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      focus = 0; mode = MODE_CONT;
      en[0][0] = 1'b1; en[0][1] = 1'b1;
      new_req(0, 0); new_req(0, 1);
      lat[0] = 1;
      run_until(4, 40, "back_to_back");
      check_order("back_to_back", '{0, 1, 0, 1});
      check_spacing("back_to_back", 3);
   endtask

   task automatic test_rr4();
      do_reset();
      focus = 1;
      en[1][3] = 1'b1; new_req(1, 3);
      lat[1] = 0;
      run_until(1, 10, "rr4_first");
      en[1][1] = 1'b1; new_req(1, 1); new_req(1, 3);
      run_until(3, 20, "rr4");
      check_order("rr4", '{3, 1, 3});
   endtask

   task automatic test_read();
      do_reset();
      focus = 0;
      fixed_rdata_en = 1'b1; fixed_rdata = 32'hDEADBEEF;
      en[0][1] = 1'b1;
      mreq[0][1] = '{valid: 1'b1, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0};
      lat[0] = 2;
      run_until(1, 20, "read");
      check_order("read", '{1});
      vectors++;
      if (cap_r1 !== {32'hDEADBEEF, 1'b1}) begin
         miscompares++;
         $display("FAIL read slice1: got %h want %h", cap_r1, {32'hDEADBEEF, 1'b1});
      end
      vectors++;
      if (cap_r0 !== '0) begin
         miscompares++;
         $display("FAIL read slice0: got %h want 0", cap_r0);
      end
   endtask

   task automatic test_reset_busy();
      do_reset();
      focus = 0;
      en[0][0] = 1'b1; new_req(0, 0);
      lat[0] = 100;
      repeat (3) cycle();
      drive_slaves();
      #2;
      do_reset();
      focus = 0;
      en[0][0] = 1'b1; en[0][1] = 1'b1;
      new_req(0, 0); new_req(0, 1);
      lat[0] = 1;
      run_until(1, 10, "reset_busy");
      check_order("reset_busy", '{0});
   endtask

   task automatic test_single_master();
      do_reset();
      focus = 2; mode = MODE_CONT; chk_x = 1'b1;
      en[2][0] = 1'b1; new_req(2, 0);
      lat[2] = 1;
      run_until(3, 30, "n1");
      check_order("n1", '{0, 0, 0});
      check_spacing("n1", 3);
   endtask

   task automatic test_random();
      do_reset();
      mode = MODE_RAND; rand_lat = 1'b1;
      for (int inst = 0; inst < NI; inst++)
         for (int m = 0; m < NM[inst]; m++) en[inst][m] = 1'b1;
      repeat (400) cycle();
   endtask

   initial begin
      for (int inst = 0; inst < NI; inst++) begin
         sresp[inst] = '0;
         for (int m = 0; m < 4; m++) mreq[inst][m] = '0;
      end
      @(posedge clk);
      #1;
      test_reset();
      test_single_write();
      test_back_to_back();
      test_rr4();
      test_read();
      test_reset_busy();
      test_single_master();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

endmodule
